// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester, memory and response signals around the arbiter.
// The slave modport is the arbiter itself; the master modport is everything
// around it (IFU, LSU and the memory port).
interface mem_port_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single physical-memory port between the instruction fetch unit
// (read-only) and the load/store unit. One transaction is in flight at a time.
// LSU wins by default; after LSU_STREAK back-to-back LSU grants with the IFU
// waiting, the IFU is forced through so it never starves.
module mem_port_arbiter #(
    parameter int LSU_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus,
    output logic                 busy,
    output logic                 protocol_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [3:0] STREAK_MAX = 4'(LSU_STREAK);

    logic [1:0]  state;
    logic [3:0]  streak;
    logic        owner_lsu;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [7:0]  wmask_q;
    logic [31:0] ifu_rdata_q;
    logic [31:0] lsu_rdata_q;
    logic        err_q;

    logic        lsu_wins;
    logic        ifu_wins;
    logic        grant_lsu;
    logic        grant_ifu;

    // Pick the winner of the port; grants only exist in IDLE and never while reset is held.
    always_comb begin
        lsu_wins  = bus.lsu_req_valid && !(bus.ifu_req_valid && (streak == STREAK_MAX));
        ifu_wins  = bus.ifu_req_valid && !lsu_wins;
        grant_lsu = (state == IDLE) && !rst && lsu_wins;
        grant_ifu = (state == IDLE) && !rst && ifu_wins;
    end

    assign bus.ifu_req_ready  = grant_ifu;
    assign bus.lsu_req_ready  = grant_lsu;
    assign bus.mem_req_valid  = (state == ISSUE);
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;
    assign bus.ifu_resp_valid = (state == RESP) && !owner_lsu;
    assign bus.lsu_resp_valid = (state == RESP) && owner_lsu;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign busy               = (state != IDLE);
    assign protocol_err       = err_q;

    // Transaction FSM: latch the winner's request, issue it, wait for the reply, pulse the owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner_lsu   <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_lsu) begin
                        owner_lsu <= 1'b1;
                        addr_q    <= bus.lsu_addr;
                        wen_q     <= bus.lsu_wen;
                        wdata_q   <= bus.lsu_wdata;
                        wmask_q   <= bus.lsu_wmask;
                        state     <= ISSUE;
                    end else if (grant_ifu) begin
                        owner_lsu <= 1'b0;
                        addr_q    <= bus.ifu_addr;
                        wen_q     <= 1'b0;
                        wdata_q   <= '0;
                        wmask_q   <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        state <= RESP;
                        if (!owner_lsu) begin
                            ifu_rdata_q <= bus.mem_rdata;
                        end else if (!wen_q) begin
                            lsu_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Count consecutive LSU grants that made a waiting IFU lose, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_lsu) begin
            if (bus.ifu_req_valid) begin
                if (streak != STREAK_MAX) begin
                    streak <= streak + 4'd1;
                end
            end else begin
                streak <= '0;
            end
        end else if (grant_ifu) begin
            streak <= '0;
        end
    end

    // Flag any memory response that arrives when no transaction is waiting for one.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.mem_resp_valid && (state != WAIT)) begin
            err_q <= 1'b1;
        end
    end

endmodule
